fifo_read_ctrl: RTL and testbench

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

---
 rtl/fifo_read_ctrl.sv | 84 ++++++++
 tb/tb_fifo_read_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of an asynchronous FIFO.
// This block owns the binary and Gray read pointers.
// It synchronises the Gray write pointer from the write clock domain.
// From the two pointers it derives empty, occupancy, read-data valid and underflow.
module fifo_read_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   w_ptr_gray,
  input  logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] r_add,
  output logic [ADDR_WIDTH:0]   r_ptr_gray,
  output logic                  empty,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow
);

  logic [ADDR_WIDTH:0] r_ptr_bin;
  logic [ADDR_WIDTH:0] r_w_sync [SYNC_STAGES];
  logic [ADDR_WIDTH:0] w_sync_last;
  logic [ADDR_WIDTH:0] w_bin;
  logic [ADDR_WIDTH:0] w_ptr_bin_nxt;
  logic [ADDR_WIDTH:0] w_ptr_gray_nxt;
  logic                w_pop;

  // Plain flop chain bringing the Gray write pointer into the read clock domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        r_w_sync[i] <= '0;
      end
    end else begin
      r_w_sync[0] <= w_ptr_gray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_w_sync[i] <= r_w_sync[i-1];
      end
    end
  end

  assign w_sync_last = r_w_sync[SYNC_STAGES-1];

  // Gray-to-binary conversion of the synchronised write pointer: bit i is the XOR of Gray bits i and above
  always_comb begin
    w_bin = '0;
    for (int unsigned i = 0; i <= ADDR_WIDTH; i++) begin
      w_bin[i] = ^(w_sync_last >> i);
    end
  end

  assign w_pop          = rd_req && !empty;
  assign w_ptr_bin_nxt  = r_ptr_bin + {{ADDR_WIDTH{1'b0}}, w_pop};
  assign w_ptr_gray_nxt = w_ptr_bin_nxt ^ (w_ptr_bin_nxt >> 1);

  // Read pointer pair: the Gray copy is loaded from the next binary value so both move on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr_bin  <= '0;
      r_ptr_gray <= '0;
    end else begin
      r_ptr_bin  <= w_ptr_bin_nxt;
      r_ptr_gray <= w_ptr_gray_nxt;
    end
  end

  // One-cycle status pulses: data valid after an accepted pop, underflow after a pop into empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rd_valid  <= w_pop;
      underflow <= rd_req && empty;
    end
  end

  // Empty compares two registered Gray pointers, so it can lag a write but never clears early
  assign empty    = (r_ptr_gray == w_sync_last);
  assign rd_count = w_bin - r_ptr_bin;
  assign r_add    = r_ptr_bin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl.
// The model tracks the pop count, the write count, and a delay line of write counts seen through the synchroniser.
// All outputs are derived arithmetically from those three quantities.
module tb_fifo_read_ctrl;

  localparam int AW    = 4;
  localparam int S     = 2;
  localparam int DEPTH = 1 << AW;
  localparam int MOD   = 1 << (AW + 1);

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW:0]   w_ptr_gray = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] r_add;
  logic [AW:0]   r_ptr_gray;
  logic          empty;
  logic          rd_valid;
  logic [AW:0]   rd_count;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  int   m_reads = 0;
  int   wpos    = 0;
  int   wq[$];
  bit   m_valid = 0;
  bit   m_uf    = 0;
  bit   chk_en  = 0;
  logic [AW:0] prev_gray = '0;

  fifo_read_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .reset      (reset_n),
    .w_ptr_gray (w_ptr_gray),
    .rd_req     (rd_req),
    .r_add      (r_add),
    .r_ptr_gray (r_ptr_gray),
    .empty      (empty),
    .rd_valid   (rd_valid),
    .rd_count   (rd_count),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] x;
    x = b[AW:0];
    return x ^ (x >> 1);
  endfunction

  function automatic int m_count();
    return (wq[0] - m_reads) & (MOD - 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("empty",     int'(empty),      (m_count() == 0) ? 1 : 0);
      chk("rd_count",  int'(rd_count),   m_count());
      chk("r_add",     int'(r_add),      m_reads % DEPTH);
      chk("r_ptr_gray",int'(r_ptr_gray), int'(gray(m_reads % MOD)));
      chk("rd_valid",  int'(rd_valid),   int'(m_valid));
      chk("underflow", int'(underflow),  int'(m_uf));
      chk("gray_bits_changed", $countones(r_ptr_gray ^ prev_gray), m_valid ? 1 : 0);
      prev_gray = r_ptr_gray;
    end
  end

  // One clock cycle: apply inputs, let the edge happen, advance the model, stop at the next falling edge
  task automatic step(input bit rd, input bit wadv);
    bit pop;
    bit uf;
    rd_req = rd;
    if (wadv) wpos++;
    w_ptr_gray = gray(wpos % MOD);
    pop = rd && (m_count() != 0);
    uf  = rd && (m_count() == 0);
    @(posedge clk);
    m_reads += int'(pop);
    m_valid = pop;
    m_uf    = uf;
    wq.push_back(wpos);
    void'(wq.pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    chk_en     = 0;
    reset_n    = 0;
    rd_req     = 0;
    wpos       = 0;
    w_ptr_gray = '0;
    m_reads    = 0;
    m_valid    = 0;
    m_uf       = 0;
    prev_gray  = '0;
    wq.delete();
    for (int i = 0; i < S; i++) wq.push_back(0);
    repeat (2) @(negedge clk);
    chk("reset_empty",    int'(empty),    1);
    chk("reset_rd_count", int'(rd_count), 0);
    chk("reset_r_add",    int'(r_add),    0);
    reset_n = 1;
    chk_en  = 1;
  endtask

  initial begin
    int rp;
    int wp;

    do_reset();

    // Pop from an empty FIFO: rejected, underflow pulse, pointer still
    step(1, 0);
    chk("uf_pulse",    int'(underflow), 1);
    chk("uf_no_valid", int'(rd_valid),  0);
    chk("uf_r_add",    int'(r_add),     0);
    step(0, 0);
    chk("uf_cleared",  int'(underflow), 0);

    // Single write: visible after exactly two edges, then a single pop
    step(0, 1);
    chk("sync_lat_1edge_empty", int'(empty), 1);
    step(0, 0);
    chk("sync_lat_2edge_empty", int'(empty),    0);
    chk("sync_lat_count",       int'(rd_count), 1);
    step(1, 0);
    chk("pop1_r_add",    int'(r_add),    1);
    chk("pop1_rd_valid", int'(rd_valid), 1);
    chk("pop1_empty",    int'(empty),    1);

    // Fill to full, then drain with back-to-back pops
    do_reset();
    repeat (DEPTH) step(0, 1);
    repeat (S) step(0, 0);
    chk("full_count", int'(rd_count), DEPTH);
    chk("full_gray_w", int'(w_ptr_gray), 5'b11000);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_r_add", int'(r_add), i);
      step(1, 0);
    end
    chk("drain_wrap_r_add", int'(r_add),      0);
    chk("drain_r_ptr_gray", int'(r_ptr_gray), 5'b11000);
    chk("drain_empty",      int'(empty),      1);
    step(1, 0);
    chk("drain_underflow",  int'(underflow),  1);

    // Steady push/pop pairs across the pointer wrap
    do_reset();
    repeat (2) step(0, 1);
    repeat (S) step(0, 0);
    for (int i = 1; i <= 40; i++) begin
      step(1, 1);
      if (i == 32) begin
        chk("wrap32_r_ptr_gray", int'(r_ptr_gray), 0);
        chk("wrap32_r_add",      int'(r_add),      0);
      end
    end
    chk("pairs_r_add", int'(r_add), 40 % DEPTH);

    // Pop and write in the same cycle
    do_reset();
    repeat (3) step(0, 1);
    repeat (S) step(0, 0);
    chk("simul_pre_count", int'(rd_count), 3);
    step(1, 1);
    chk("simul_count_after_pop", int'(rd_count), 2);
    step(0, 0);
    chk("simul_count_after_sync", int'(rd_count), 3);

    // Asynchronous reset mid-stream with a pending rd_valid pulse
    do_reset();
    repeat (6) step(0, 1);
    repeat (S) step(0, 0);
    step(1, 0);
    chk("midrst_pre_count", int'(rd_count), 5);
    chk("midrst_pre_valid", int'(rd_valid), 1);
    chk_en = 0;
    #3 reset_n = 0;
    #1;
    chk("midrst_empty",    int'(empty),      1);
    chk("midrst_count",    int'(rd_count),   0);
    chk("midrst_r_add",    int'(r_add),      0);
    chk("midrst_gray",     int'(r_ptr_gray), 0);
    chk("midrst_valid",    int'(rd_valid),   0);
    chk("midrst_underflow",int'(underflow),  0);

    // Randomised traffic in phases of differing read/write pressure
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0: begin rp = 20; wp = 90; end
        1: begin rp = 80; wp = 20; end
        2: begin rp = 50; wp = 55; end
        default: begin rp = 5; wp = 100; end
      endcase
      for (int c = 0; c < 400; c++) begin
        bit rd;
        bit wr;
        rd = ($urandom_range(0, 99) < rp);
        wr = ($urandom_range(0, 99) < wp) && ((wpos - m_reads) < DEPTH);
        step(rd, wr);
      end
    end
    repeat (S + 1) step(0, 0);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
